// File: rtl/i_cache_ctrl_if.sv
// Fetch-side and refill-side signal bundle for the direct-mapped instruction cache controller.
// Optional hit/miss counters appear only when ICACHE_STATS_EN is defined.
interface i_cache_ctrl_if;
    logic [31:0]  rd_addr;
    logic         rd_en;
    logic         abort;
    logic [127:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic         mem_rvalid;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;
`endif

    modport slave (
        input  rd_addr, rd_en, abort, mem_rdata, mem_rvalid,
        output dout, dout_valid, busy, mem_req, mem_addr
`ifdef ICACHE_STATS_EN
        , output hit_cnt, miss_cnt
`endif
    );

    modport master (
        output rd_addr, rd_en, abort, mem_rdata, mem_rvalid,
        input  dout, dout_valid, busy, mem_req, mem_addr
`ifdef ICACHE_STATS_EN
        , input hit_cnt, miss_cnt
`endif
    );
endinterface

// File: rtl/i_cache_ctrl.sv
// Direct-mapped 128-bit-line instruction cache controller with 4-beat refill and branch abort.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module i_cache_ctrl #(
    parameter int NUM_LINES    = 16,
    parameter int REFILL_BEATS = 4
) (
    input  logic          clk,
    input  logic          rst,
    i_cache_ctrl_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 28 - IDX_W;
    localparam int BEAT_W = $clog2(REFILL_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESPOND} state_t;

    state_t             r_state;
    logic [BEAT_W-1:0]  r_beat;
    logic               r_abort_pend;
    logic               r_hit_valid;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;
    logic [127:0]       r_dout;
    logic [95:0]        r_line;
    logic [NUM_LINES-1:0] r_valid;
    logic [127:0]       r_data_mem [NUM_LINES];
    logic [TAG_W-1:0]   r_tag_mem  [NUM_LINES];

    logic [IDX_W-1:0]   w_rd_idx;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [IDX_W-1:0]   w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_req;
    logic               w_hit;
    logic               w_beat_we;
    logic               w_last_beat;
    logic [127:0]       w_fill_line;
    logic               w_unused;

    assign w_rd_idx    = bus.rd_addr[4 +: IDX_W];
    assign w_rd_tag    = bus.rd_addr[31 -: TAG_W];
    assign w_fill_idx  = r_mem_addr[4 +: IDX_W];
    assign w_fill_tag  = r_mem_addr[31 -: TAG_W];
    assign w_req       = (r_state == S_IDLE) && bus.rd_en && !bus.abort;
    assign w_hit       = r_valid[w_rd_idx] && (r_tag_mem[w_rd_idx] == w_rd_tag);
    assign w_beat_we   = (r_state == S_REFILL) && bus.mem_rvalid;
    assign w_last_beat = w_beat_we && (r_beat == '1);
    // The final beat goes straight into the line write; only words 0..2 need staging.
    assign w_fill_line = {bus.mem_rdata, r_line};
    assign w_unused    = ^bus.rd_addr[3:0];

    always_ff @(posedge clk) begin
        for (int i = 0; i < REFILL_BEATS - 1; i++) begin
            if (w_beat_we && (r_beat == BEAT_W'(i)))
                r_line[i*32 +: 32] <= bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_last_beat) begin
            r_data_mem[w_fill_idx] <= w_fill_line;
            r_tag_mem[w_fill_idx]  <= w_fill_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_abort_pend <= 1'b0;
            r_hit_valid  <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_dout       <= '0;
            r_valid      <= '0;
        end else begin
            r_hit_valid <= 1'b0;
            r_mem_req   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            r_dout      <= r_data_mem[w_rd_idx];
                            r_hit_valid <= 1'b1;
                        end else begin
                            r_mem_addr   <= {bus.rd_addr[31:4], 4'b0000};
                            r_mem_req    <= 1'b1;
                            r_beat       <= '0;
                            r_abort_pend <= 1'b0;
                            r_state      <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (bus.abort)
                        r_abort_pend <= 1'b1;
                    if (w_beat_we) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            // Line is installed even when the fetch was redirected.
                            r_valid[w_fill_idx] <= 1'b1;
                            if (r_abort_pend || bus.abort) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_dout  <= w_fill_line;
                                r_state <= S_RESPOND;
                            end
                        end
                    end
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_req && w_hit && (r_hit_cnt != 16'hFFFF))
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_req && !w_hit && (r_miss_cnt != 16'hFFFF))
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
`endif

    // A same-cycle redirect suppresses the refill response.
    assign bus.dout_valid = r_hit_valid || ((r_state == S_RESPOND) && !bus.abort);
    assign bus.dout       = r_dout;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
endmodule

// File: tb/tb_i_cache_ctrl.sv
// Directed bench for i_cache_ctrl: cycle-by-cycle vector table plus hand sequences for
// abort-in-RESPOND, reset mid-refill and (with ICACHE_STATS_EN) the counters.
module tb_i_cache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i_cache_ctrl_if bus();

    i_cache_ctrl #(.NUM_LINES(16), .REFILL_BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]  addr;
        logic         rd_en;
        logic         abort;
        logic         rvalid;
        logic [31:0]  rdata;
        logic         exp_dv;
        logic         exp_req;
        logic         exp_busy;
        logic [127:0] exp_dout;
        logic [31:0]  exp_maddr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic rd_en, input logic abort,
                         input logic rvalid, input logic [31:0] rdata);
        bus.rd_addr    = addr;
        bus.rd_en      = rd_en;
        bus.abort      = abort;
        bus.mem_rvalid = rvalid;
        bus.mem_rdata  = rdata;
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic rd_en, input logic abort,
                                input logic rvalid, input logic [31:0] rdata,
                                input logic dv, input logic req, input logic busy,
                                input logic [127:0] dout, input logic [31:0] maddr);
        vec_t v;
        v.addr = addr; v.rd_en = rd_en; v.abort = abort; v.rvalid = rvalid; v.rdata = rdata;
        v.exp_dv = dv; v.exp_req = req; v.exp_busy = busy; v.exp_dout = dout; v.exp_maddr = maddr;
        return v;
    endfunction

    function automatic logic [127:0] line4(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    logic [127:0] la, lb, lc, ld, lf;
    logic         got;
    int           k;

    initial begin
        la = line4(32'hA0);
        lb = line4(32'hB0);
        lc = line4(32'hC0);
        ld = line4(32'hD0);
        lf = line4(32'hF0);
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // miss 0x100, fill A0..A3, RESPOND
        vecs.push_back(mk(32'h100, 1, 0, 0, 32'h0,  0, 1, 1, '0, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hA0, 0, 0, 1, '0, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hA1, 0, 0, 1, '0, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hA2, 0, 0, 1, '0, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hA3, 1, 0, 1, la, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 0, 32'h0,  0, 0, 0, '0, 32'h0));
        // back-to-back hits, dropped requests, stray beat in IDLE
        vecs.push_back(mk(32'h10C, 1, 0, 0, 32'h0,  1, 0, 0, la, 32'h0));
        vecs.push_back(mk(32'h10C, 1, 0, 0, 32'h0,  1, 0, 0, la, 32'h0));
        vecs.push_back(mk(32'h10C, 1, 1, 0, 32'h0,  0, 0, 0, '0, 32'h0));
        vecs.push_back(mk(32'h300, 1, 1, 0, 32'h0,  0, 0, 0, '0, 32'h0));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hDEAD, 0, 0, 0, '0, 32'h0));
        // miss 0x200 with abort on 2nd beat: no response, line still installed
        vecs.push_back(mk(32'h200, 1, 0, 0, 32'h0,  0, 1, 1, '0, 32'h200));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hB0, 0, 0, 1, '0, 32'h200));
        vecs.push_back(mk(32'h0,   0, 1, 1, 32'hB1, 0, 0, 1, '0, 32'h200));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hB2, 0, 0, 1, '0, 32'h200));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hB3, 0, 0, 0, '0, 32'h0));
        vecs.push_back(mk(32'h0,   0, 0, 0, 32'h0,  0, 0, 0, '0, 32'h0));
        vecs.push_back(mk(32'h200, 1, 0, 0, 32'h0,  1, 0, 0, lb, 32'h0));
        // conflict: 0x100 was evicted by 0x200
        vecs.push_back(mk(32'h100, 1, 0, 0, 32'h0,  0, 1, 1, '0, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hC0, 0, 0, 1, '0, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hC1, 0, 0, 1, '0, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hC2, 0, 0, 1, '0, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hC3, 1, 0, 1, lc, 32'h100));
        vecs.push_back(mk(32'h0,   0, 0, 1, 32'hEE, 0, 0, 0, '0, 32'h0));
        vecs.push_back(mk(32'h10C, 1, 0, 0, 32'h0,  1, 0, 0, lc, 32'h0));
        vecs.push_back(mk(32'h0,   0, 0, 0, 32'h0,  0, 0, 0, '0, 32'h0));

        // reset state
        #3 rst = 1'b0;
        tick();
        tick();
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_dv", 128'(bus.dout_valid), 128'd0);
        chk("rst_req", 128'(bus.mem_req), 128'd0);
        chk("rst_dout", bus.dout, 128'd0);
        chk("rst_maddr", 128'(bus.mem_addr), 128'd0);
        rst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].rd_en, vecs[i].abort, vecs[i].rvalid, vecs[i].rdata);
            tick();
            $display("vec %0d addr=%h rd_en=%b abort=%b rvalid=%b -> dv=%b req=%b busy=%b",
                     i, vecs[i].addr, vecs[i].rd_en, vecs[i].abort, vecs[i].rvalid,
                     bus.dout_valid, bus.mem_req, bus.busy);
            chk($sformatf("v%0d_dv", i), 128'(bus.dout_valid), 128'(vecs[i].exp_dv));
            chk($sformatf("v%0d_req", i), 128'(bus.mem_req), 128'(vecs[i].exp_req));
            chk($sformatf("v%0d_busy", i), 128'(bus.busy), 128'(vecs[i].exp_busy));
            if (vecs[i].exp_dv)
                chk($sformatf("v%0d_dout", i), bus.dout, vecs[i].exp_dout);
            if (vecs[i].exp_busy)
                chk($sformatf("v%0d_maddr", i), 128'(bus.mem_addr), 128'(vecs[i].exp_maddr));
        end

        // abort during the RESPOND cycle masks dout_valid; line stays installed
        drive(32'h400, 1, 0, 0, 32'h0);
        tick();
        chk("s1_req", 128'(bus.mem_req), 128'd1);
        for (int b = 0; b < 4; b++) begin
            drive(32'h0, 0, 0, 1, 32'hD0 + 32'(b));
            tick();
        end
        drive(32'h0, 0, 0, 0, 32'h0);
        #1;
        $display("seq1 respond dv=%b busy=%b", bus.dout_valid, bus.busy);
        chk("s1_dv_pre", 128'(bus.dout_valid), 128'd1);
        chk("s1_dout", bus.dout, ld);
        bus.abort = 1'b1;
        #1;
        chk("s1_dv_abort", 128'(bus.dout_valid), 128'd0);
        bus.abort = 1'b0;
        tick();
        chk("s1_busy_after", 128'(bus.busy), 128'd0);
        drive(32'h400, 1, 0, 0, 32'h0);
        tick();
        chk("s1_hit_dv", 128'(bus.dout_valid), 128'd1);
        chk("s1_hit_dout", bus.dout, ld);
        drive(32'h0, 0, 0, 0, 32'h0);
        tick();

        // reset in the middle of a refill, then stray beats, then a clean miss
        drive(32'h100, 1, 0, 0, 32'h0);
        tick();
        chk("s2_req", 128'(bus.mem_req), 128'd1);
        drive(32'h0, 0, 0, 1, 32'hE0);
        tick();
        drive(32'h0, 0, 0, 1, 32'hE1);
        tick();
        drive(32'h0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        #1;
        $display("seq2 reset mid-refill busy=%b dout=%h", bus.busy, bus.dout);
        chk("s2_rst_busy", 128'(bus.busy), 128'd0);
        chk("s2_rst_dout", bus.dout, 128'd0);
        chk("s2_rst_maddr", 128'(bus.mem_addr), 128'd0);
        tick();
        tick();
        rst = 1'b1;
        drive(32'h0, 0, 0, 1, 32'hE2);
        tick();
        chk("s2_stray_busy", 128'(bus.busy), 128'd0);
        drive(32'h0, 0, 0, 1, 32'hE3);
        tick();
        chk("s2_stray_dv", 128'(bus.dout_valid), 128'd0);
        drive(32'h100, 1, 0, 0, 32'h0);
        tick();
        chk("s2_miss_req", 128'(bus.mem_req), 128'd1);
        chk("s2_miss_maddr", 128'(bus.mem_addr), 128'h100);
        got = 1'b0;
        k = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            drive(32'h0, 0, 0, 1, 32'hF0 + 32'(k));
            k++;
            tick();
            if (bus.dout_valid) got = 1'b1;
        end
        $display("seq2 refill done=%b beats=%0d", got, k);
        chk("s2_fill_done", 128'(got), 128'd1);
        chk("s2_fill_beats", 128'(k), 128'd4);
        chk("s2_fill_dout", bus.dout, lf);
        drive(32'h0, 0, 0, 0, 32'h0);
        tick();

`ifdef ICACHE_STATS_EN
        for (int h = 0; h < 3; h++) begin
            drive(32'h100, 1, 0, 0, 32'h0);
            tick();
        end
        drive(32'h500, 1, 0, 0, 32'h0);
        tick();
        for (int b = 0; b < 4; b++) begin
            drive(32'h0, 0, 0, 1, 32'h50 + 32'(b));
            tick();
        end
        drive(32'h0, 0, 0, 0, 32'h0);
        tick();
        $display("stats hit=%0d miss=%0d", bus.hit_cnt, bus.miss_cnt);
        chk("st_hit3", 128'(bus.hit_cnt), 128'd3);
        chk("st_miss2", 128'(bus.miss_cnt), 128'd2);
        drive(32'h500, 1, 0, 0, 32'h0);
        for (int c = 0; c < 70000 && bus.hit_cnt != 16'hFFFF; c++) tick();
        chk("st_hit_max", 128'(bus.hit_cnt), 128'hFFFF);
        tick();
        $display("stats saturate hit=%h", bus.hit_cnt);
        chk("st_hit_sat", 128'(bus.hit_cnt), 128'hFFFF);
        chk("st_miss_keep", 128'(bus.miss_cnt), 128'd2);
        drive(32'h0, 0, 0, 0, 32'h0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/i_cache_ctrl.md
I_CACHE_CTRL -- requirements
Module: i_cache_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 16, giving the number of direct-mapped 128-bit lines; legal values are powers of 2 from 4 to 256.
REQ-002 The block SHALL have parameter REFILL_BEATS, default 4, giving the number of 32-bit memory beats per line; it is fixed at 4 (any other value is illegal).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rd_addr  input  32  fetch byte address; bits [3:0] are ignored (line-aligned access).
REQ-006 rd_en  input  1  fetch request, sampled only when busy=0.
REQ-007 abort  input  1  cancel the outstanding or same-cycle fetch (branch redirect).
REQ-008 dout  output  128  fetched line; word k is at bits [32k+31:32k].
REQ-009 dout_valid  output  1  one-cycle pulse qualifying dout.
REQ-010 busy  output  1  high when the controller is not in IDLE; rd_en is ignored while busy=1.
REQ-011 mem_req  output  1  one-cycle refill request pulse.
REQ-012 mem_addr  output  32  line-aligned refill address ({tag,index,4'b0}), held stable from the mem_req cycle until the last beat.
REQ-013 mem_rdata  input  32  refill data beat.
REQ-014 mem_rvalid  input  1  qualifies mem_rdata; beats arrive in order, word 0 first.

Function
REQ-015 Address split SHALL be: index = rd_addr[3+log2(NUM_LINES):4] and tag = rd_addr[31:4+log2(NUM_LINES)]; each line SHALL store tag, valid bit and 128 data bits.
REQ-016 The FSM SHALL have states IDLE, REFILL and RESPOND.
REQ-017 IDLE, rd_en=1, abort=0, hit: the block SHALL update dout with the line and pulse dout_valid=1 in the next cycle; the FSM SHALL stay in IDLE (back-to-back hits give one line per cycle).
REQ-018 IDLE, rd_en=1, abort=0, miss: the block SHALL latch the address, pulse mem_req in the next cycle and go to REFILL.
REQ-019 IDLE, rd_en=1, abort=1: the request SHALL be dropped, with no dout_valid and no mem_req.
REQ-020 REFILL SHALL place each mem_rvalid beat into word slot 0,1,2,3 in turn, using a 2-bit beat counter.
REQ-021 On the 4th beat the block SHALL write the line, tag and valid=1 into the array.
REQ-022 On the 4th beat with no abort pending, the FSM SHALL go to RESPOND.
REQ-023 On the 4th beat with an abort pending, the FSM SHALL go to IDLE; the line is still installed.
REQ-024 abort=1 at any cycle in REFILL SHALL set an abort-pending flag; the refill SHALL continue to completion.
REQ-025 RESPOND SHALL drive dout equal to the refilled line and dout_valid=1 for exactly one cycle, then return to IDLE.
REQ-026 abort=1 during the RESPOND cycle SHALL force dout_valid=0.
REQ-027 mem_rvalid while the FSM is in IDLE or RESPOND SHALL be ignored.
REQ-028 Miss latency SHALL be 1 cycle to mem_req, plus the memory latency, plus 1 cycle RESPOND after the last beat.
REQ-029 busy SHALL be combinational from the state (state != IDLE).

Reset
REQ-030 Assertion of rst SHALL immediately clear every valid bit and set state=IDLE, beat counter=0, abort-pending=0, dout_valid=0, mem_req=0, busy=0, dout=0 and mem_addr=0.
REQ-031 Reset asserted mid-REFILL SHALL abandon the refill and install no line; beats arriving after reset release SHALL be ignored.
REQ-032 Data and tag arrays need no reset.

Configuration
REQ-033 Macro ICACHE_STATS_EN defined: the block SHALL add outputs hit_cnt[15:0] and miss_cnt[15:0], both reset to 0.
REQ-034 With ICACHE_STATS_EN, each accepted non-aborted hit SHALL increment hit_cnt and each refill start SHALL increment miss_cnt; both saturate at 16'hFFFF.
REQ-035 Macro ICACHE_STATS_EN undefined: the block SHALL have no counter ports or logic; all other behaviour is identical.

Verification
REQ-036 Reset release, rd_addr=0x100 rd_en=1 -> mem_req next cycle with mem_addr=0x100; 4 beats 0xA0..0xA3 -> RESPOND with dout=0x000000A3_000000A2_000000A1_000000A0 and dout_valid=1 one cycle.
REQ-037 Repeat rd_addr=0x10C after that fill -> hit, dout_valid next cycle with the same line, no mem_req.
REQ-038 Miss on 0x200, abort in the 2nd beat cycle -> 4 beats consumed, no dout_valid, busy=0 after the last beat; later rd 0x200 hits.
REQ-039 Conflict: fill 0x100 then rd 0x200 (NUM_LINES=16, same index 0) -> miss, refill replaces the line; rd 0x100 then misses again.
REQ-040 rst asserted mid-REFILL after 2 beats -> outputs 0 immediately; rd 0x100 after release misses; stray mem_rvalid while in IDLE is ignored.
REQ-041 ICACHE_STATS_EN: 3 hits plus 2 misses -> hit_cnt=3, miss_cnt=2; preload hit_cnt=0xFFFF and add 1 hit -> hit_cnt stays 0xFFFF.
